// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the square-root scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: operand width, root-unit pipeline depth, the in-flight tag
// record and a small population-count helper.
package fp_sqrt_pkg;

  localparam int FP_WIDTH     = 32;
  // Pipeline depth of the shared FP_SquareRoot unit (operand edge to
  // result-sampling edge).
  localparam int SQRT_LATENCY = 3;

  // Tag index is sized for the largest supported requester count so the
  // struct is a fixed type; smaller configurations leave the top bits zero.
  localparam int MAX_REQ   = 8;
  localparam int TAG_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic int unsigned count_ones(input logic [MAX_REQ-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_sqrt_scheduler_rr_arbiter.sv
// Round-robin picker: first eligible index scanning ptr, ptr+1, ... mod NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides eligibility.
//
// Ports: eligible (request mask), ptr (highest-priority index),
//        grant (one-hot), grant_idx (binary index of grant), any_grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  int               cand;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr is always < NUM_REQ, so one subtraction is enough to wrap.
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cidx = IDX_W'(cand);
      if (!any_grant && eligible[cidx]) begin
        any_grant   = 1'b1;
        grant_idx   = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_scheduler.sv
// Shares one fixed-latency pipelined square-root unit among NUM_REQ requesters.
// Latency: grant at edge E, response registered and visible after edge E+LATENCY.
// Backpressure: one outstanding op per requester; a held response only blocks its own requester.
//
// Ports: clk/rst (async active-high), req_valid/req_data/req_ready (one-hot
//        operand handshake), rsp_valid/rsp_data/rsp_ready (per-requester
//        result handshake), sqrt_operand/sqrt_result (root unit data_i/data_o),
//        inflight (number of requesters granted but not yet drained).
module fp_sqrt_scheduler
  import fp_sqrt_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = FP_WIDTH,
  parameter int LATENCY   = SQRT_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*DATAWIDTH-1:0]   rsp_data,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATAWIDTH-1:0]           sqrt_operand,
  input  logic [DATAWIDTH-1:0]           sqrt_result,
  output logic [$clog2(NUM_REQ+1)-1:0]   inflight
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_REQ+1);

  logic [IDX_W-1:0]             ptr_q, ptr_d;
  logic [NUM_REQ-1:0]           busy_q, busy_d;
  tag_t [LATENCY-1:0]           tag_q, tag_d;
  logic [DATAWIDTH-1:0]         sqrt_operand_q, sqrt_operand_d;
  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATAWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]             inflight_q, inflight_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;
  logic [NUM_REQ-1:0] rsp_fire;
  tag_t               tag_last;

  // A busy requester is masked until its response drains, which is what
  // guarantees the root unit never needs a stall.
  always_comb begin
    eligible = req_valid & ~busy_q & {NUM_REQ{~rst}};
    rsp_fire = rsp_valid_q & rsp_ready;
    tag_last = tag_q[LATENCY-1];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    ptr_d          = ptr_q;
    sqrt_operand_d = sqrt_operand_q;
    tag_d          = '0;
    busy_d         = (busy_q | grant) & ~rsp_fire;
    rsp_valid_d    = rsp_valid_q & ~rsp_fire;
    rsp_data_d     = rsp_data_q;
    inflight_d     = '0;

    if (any_grant) begin
      ptr_d = (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + IDX_W'(1);
    end

    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sqrt_operand_d = req_data[k*DATAWIDTH +: DATAWIDTH];
      end
    end

    // Tag pipeline mirrors the root unit: shifts every cycle, bubble when idle.
    tag_d[0].valid = any_grant;
    tag_d[0].idx   = TAG_IDX_W'(grant_idx);
    for (int s = 1; s < LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    // The owning requester is still busy, so its response slot is empty here
    // and the write cannot collide with a pending rsp_fire.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (tag_last.valid && (tag_last.idx == TAG_IDX_W'(k))) begin
        rsp_valid_d[k]                        = 1'b1;
        rsp_data_d[k*DATAWIDTH +: DATAWIDTH]  = sqrt_result;
      end
    end

    inflight_d = CNT_W'(count_ones(MAX_REQ'(busy_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      busy_q         <= '0;
      tag_q          <= '0;
      sqrt_operand_q <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      inflight_q     <= '0;
    end else begin
      ptr_q          <= ptr_d;
      busy_q         <= busy_d;
      tag_q          <= tag_d;
      sqrt_operand_q <= sqrt_operand_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      inflight_q     <= inflight_d;
    end
  end

  assign req_ready    = grant;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign sqrt_operand = sqrt_operand_q;
  assign inflight     = inflight_q;

endmodule

// File: tb/tb_fp_sqrt_scheduler.sv
// Bench for fp_sqrt_scheduler: stand-in root unit plus a transaction-level
// model (outstanding set, rotating priority, per-requester expected result).
module tb_fp_sqrt_scheduler;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int CW  = $clog2(N+1);
  localparam int NR  = (LAT > 1) ? LAT-1 : 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [N*DW-1:0]   rsp_data;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     sqrt_operand;
  logic [DW-1:0]     sqrt_result;
  logic [CW-1:0]     inflight;

  always #5 clk = ~clk;

  fp_sqrt_scheduler #(.NUM_REQ(N), .DATAWIDTH(DW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .sqrt_operand (sqrt_operand),
    .sqrt_result  (sqrt_result),
    .inflight     (inflight)
  );

  // Stand-in root unit: exact roots for a few perfect squares, any fixed
  // function elsewhere (the scheduler never looks at the numbers).
  logic [31:0] sq_in  [7] = '{32'h3F800000, 32'h40800000, 32'h41100000, 32'h41800000,
                              32'h41C80000, 32'h42800000, 32'h3E800000};
  logic [31:0] sq_out [7] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h41000000, 32'h3F000000};

  function automatic logic [31:0] root_f(input logic [31:0] x);
    logic [31:0] r;
    r = {1'b0, x[31:1]} ^ 32'h1234_5678;
    for (int i = 0; i < 7; i++) if (x === sq_in[i]) r = sq_out[i];
    return r;
  endfunction

  logic [DW-1:0]    f0;
  logic [NR*DW-1:0] rsh;
  always_comb f0 = root_f(sqrt_operand);
  always @(posedge clk) rsh <= (rsh << DW) | (NR*DW)'(f0);
  assign sqrt_result = (LAT == 1) ? f0 : rsh[NR*DW-1 -: DW];

  // ---------------- reference model state ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [N-1:0] busy_m;
  int          launch_m [N];
  logic [31:0] op_m [N];
  logic [31:0] rdat_m [N];
  logic [31:0] opreg_m;
  int          ptr_m;
  int          peak;
  int          g_idx[$];
  int          g_cyc[$];
  int          r_idx[$];
  int          r_cyc[$];
  logic [31:0] r_dat[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare everything mid-cycle, take the edge, advance the model.
  task automatic cycle();
    logic [N-1:0]    exp_rdy, exp_rv, hs;
    logic [N*DW-1:0] exp_rd;
    int g;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr_m + k) % N;
        if (g < 0 && req_valid[c] && !busy_m[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int k = 0; k < N; k++) begin
      exp_rv[k] = busy_m[k] && (cyc >= launch_m[k] + LAT);
      exp_rd[k*DW +: DW] = rdat_m[k];
    end
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    check("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
    check("rsp_data", 128'(rsp_data), 128'(exp_rd));
    check("sqrt_operand", 128'(sqrt_operand), 128'(opreg_m));
    check("inflight", 128'(inflight), 128'($countones(busy_m)));
    if (int'(inflight) > peak) peak = int'(inflight);
    hs = exp_rv & rsp_ready;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        r_idx.push_back(k);
        r_cyc.push_back(cyc + 1);
        r_dat.push_back(rsp_data[k*DW +: DW]);
      end
    end
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      busy_m[g]   = 1'b1;
      launch_m[g] = cyc;
      op_m[g]     = req_data[g*DW +: DW];
      opreg_m     = op_m[g];
      ptr_m       = (g + 1) % N;
      g_idx.push_back(g);
      g_cyc.push_back(cyc);
    end
    busy_m = busy_m & ~hs;
    for (int k = 0; k < N; k++) begin
      if (busy_m[k] && cyc == launch_m[k] + LAT) rdat_m[k] = root_f(op_m[k]);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_data", 128'(rsp_data), 128'(0));
    check("rst_operand", 128'(sqrt_operand), 128'(0));
    check("rst_inflight", 128'(inflight), 128'(0));
    busy_m  = '0;
    ptr_m   = 0;
    opreg_m = '0;
    for (int k = 0; k < N; k++) rdat_m[k] = '0;
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (LAT + 3) cycle();
  endtask

  initial begin
    int b, rb, n0, n1;
    logic [31:0] held;
    logic [N-1:0] done;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_data = '0;
    peak = 0;

    // 1) single operation
    do_reset();
    req_data  = {32'h0, 32'h0, 32'h0, 32'h40800000};
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    check("t1_operand", 128'(sqrt_operand), 128'(32'h40800000));
    check("t1_inflight1", 128'(inflight), 128'(1));
    repeat (LAT - 1) cycle();
    check("t1_early_valid", 128'(rsp_valid), 128'(0));
    cycle();
    check("t1_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    check("t1_rsp_data", 128'(rsp_data[31:0]), 128'(32'h40000000));
    rsp_ready = 4'b0001;
    cycle();
    check("t1_inflight0", 128'(inflight), 128'(0));
    check("t1_rsp_gone", 128'(rsp_valid), 128'(0));

    // 2) all four at once
    do_reset();
    b = g_idx.size(); rb = r_idx.size(); peak = 0; done = '0;
    req_data  = {32'h41800000, 32'h41100000, 32'h40800000, 32'h3F800000};
    rsp_ready = '1;
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      done |= busy_m;
      req_valid = ~done;
    end
    check("t2_ngrants", 128'(g_idx.size() - b), 128'(4));
    check("t2_nrsp", 128'(r_idx.size() - rb), 128'(4));
    for (int k = 0; k < 4; k++) begin
      check("t2_grant_order", 128'(g_idx[b+k]), 128'(k));
      check("t2_grant_cyc", 128'(g_cyc[b+k] - g_cyc[b]), 128'(k));
      check("t2_rsp_order", 128'(r_idx[rb+k]), 128'(k));
      check("t2_rsp_cyc", 128'(r_cyc[rb+k] - g_cyc[b+k]), 128'(LAT + 1));
    end
    check("t2_rsp0", 128'(r_dat[rb+0]), 128'(32'h3F800000));
    check("t2_rsp1", 128'(r_dat[rb+1]), 128'(32'h40000000));
    check("t2_rsp2", 128'(r_dat[rb+2]), 128'(32'h40400000));
    check("t2_rsp3", 128'(r_dat[rb+3]), 128'(32'h40800000));
    check("t2_peak", 128'(peak), 128'(4));

    // 3) fairness between req0 and req2
    b = g_idx.size();
    req_data  = {32'h0, 32'h41C80000, 32'h0, 32'h42800000};
    req_valid = 4'b0101;
    rsp_ready = '1;
    repeat (30) cycle();
    check("t3_enough", 128'(g_idx.size() - b >= 6), 128'(1));
    for (int k = b + 1; k < g_idx.size(); k++) begin
      check("t3_alternate", 128'(g_idx[k] != g_idx[k-1]), 128'(1));
    end
    drain();

    // 4) held response on requester 1
    req_data  = {32'h0, 32'h0, 32'h3E800000, 32'h41100000};
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    repeat (LAT + 1) cycle();
    check("t4_rsp1_valid", 128'(rsp_valid[1]), 128'(1));
    held = rsp_data[63:32];
    check("t4_rsp1_data", 128'(held), 128'(32'h3F000000));
    b = g_idx.size();
    req_valid = 4'b0011;
    repeat (10) begin
      cycle();
      check("t4_stable", 128'(rsp_data[63:32]), 128'(held));
    end
    n0 = 0; n1 = 0;
    for (int k = b; k < g_idx.size(); k++) begin
      if (g_idx[k] == 0) n0++;
      if (g_idx[k] == 1) n1++;
    end
    check("t4_no_regrant1", 128'(n1), 128'(0));
    check("t4_req0_served", 128'(n0 > 0), 128'(1));
    drain();

    // 5) reset mid-flight
    req_data  = {32'h41800000, 32'h0, 32'h40800000, 32'h0};
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    cycle();
    do_reset();
    rsp_ready = '1;
    repeat (LAT + 3) begin
      cycle();
      check("t5_no_rsp", 128'(rsp_valid), 128'(0));
    end
    req_valid = 4'b0010;
    cycle();
    do_reset();
    req_valid = '1;
    cycle();
    check("t5_ptr_restart", 128'(g_idx[g_idx.size()-1]), 128'(0));
    drain();

    // 6) re-issue gap for one requester
    b = g_idx.size(); rb = r_idx.size();
    req_data  = {32'h0, 32'h0, 32'h42800000, 32'h0};
    req_valid = 4'b0010;
    rsp_ready = '1;
    repeat (12) cycle();
    check("t6_lat", 128'(r_cyc[rb] - g_cyc[b]), 128'(LAT + 1));
    check("t6_gap", 128'(g_cyc[b+1] - r_cyc[rb]), 128'(1));
    check("t6_rsp", 128'(r_dat[rb]), 128'(32'h41000000));
    drain();

    // 7) randomized traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      for (int k = 0; k < N; k++) begin
        req_data[k*DW +: DW] = ($urandom_range(0, 1) == 1) ? sq_in[$urandom_range(0, 6)] : $urandom;
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_scheduler.md
Name: fp_sqrt_scheduler

Overview:
Shares one pipelined FP_SquareRoot unit (32-bit IEEE-754 single, fixed latency, no stall input) among NUM_REQ requesters.
- Round-robin arbitration picks the next operand.
- Drives the operand into the root unit.
- Tracks each in-flight operation with a tag pipeline.
- Returns each result to the requester that issued it, through a per-requester valid/ready response port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATAWIDTH, 32, operand/result width
LATENCY, 3, edges from sqrt_operand update to sqrt_result valid for sampling (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  request i holds an operand
req_data  in  NUM_REQ*DATAWIDTH  operand of requester i, slice [i*DATAWIDTH +: DATAWIDTH]
req_ready  out  NUM_REQ  one-hot grant; the operand transfers on the edge where valid&ready
rsp_valid  out  NUM_REQ  result i available
rsp_data  out  NUM_REQ*DATAWIDTH  result of requester i
rsp_ready  in  NUM_REQ  requester i accepts the result
sqrt_operand  out  DATAWIDTH  registered operand driving root unit data_i
sqrt_result  in  DATAWIDTH  root unit data_o
inflight  out  $clog2(NUM_REQ+1)  count of granted requesters whose response is not yet consumed

Behaviour:
- Reset values (async, immediate): req_ready=0, rsp_valid=0, rsp_data=0, sqrt_operand=0, inflight=0, rr pointer=0, busy bits=0, tag pipeline all invalid.
- busy[i] set on the grant edge for i; cleared on the edge where rsp_valid[i]&rsp_ready[i]. Each requester has at most one operation outstanding, so results never need backpressure into the root unit.
- Eligible[i] = req_valid[i] & ~busy[i] & ~rst.
- Grant: first eligible index scanning ptr, ptr+1, ..., wrapping mod NUM_REQ. req_ready is combinational from eligible and ptr, with at most one bit high.
- On a grant edge to requester g:
  - sqrt_operand <= req_data[g].
  - Tag stage 0 <= {valid=1, idx=g}.
  - ptr <= (g+1) mod NUM_REQ.
- With no grant: sqrt_operand holds its value; ptr holds; stage 0 <= invalid.
- Tag pipeline is LATENCY stages and shifts every clk, unconditionally.
- When the last stage is valid with idx=k:
  - rsp_data[k] <= sqrt_result.
  - rsp_valid[k] <= 1.
- End-to-end timing: grant at edge E, response visible after edge E+LATENCY.
- Busy clearing and a new grant for the same requester never happen on the same edge. The requester becomes eligible one cycle after its response is consumed.
- rsp_data[k] holds stable while rsp_valid[k]=1.
- Back-to-back grants to different requesters on consecutive edges are allowed, giving full root-unit throughput.
- inflight = popcount(busy), registered.
- Simultaneous requests: ptr order decides. A requester is never starved; worst-case wait is NUM_REQ-1 grants.
- rst mid-operation clears all tags, busy bits and rsp_valid. In-flight results are discarded. Root-unit internal state is ignored because the tags are invalid.
- req_valid dropped before grant: no transfer, no state change.
- The block does no numeric processing. Special values (NaN, negative, denormal) pass through the root unit untouched.

Decomposition:
- Shared package fp_sqrt_pkg:
  - FP_WIDTH=32
  - SQRT_LATENCY, matching the root unit pipeline depth
  - tag struct {valid, idx[$clog2(NUM_REQ)-1:0]}
- One sub-module, rr_arbiter (NUM_REQ):
  - Inputs: eligible vector, ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational.
- The top level keeps ptr, busy, the tag pipeline, the operand register and the response registers.

Test Plan:
- Single op: after rst, req0 presents 0x40800000 (4.0) -> req_ready[0] that cycle; sqrt_operand=0x40800000 after the edge; rsp_valid[0] with rsp_data=0x40000000 exactly LATENCY edges later; inflight 1 then 0 after rsp_ready.
- All four valid at once with 0x3F800000, 0x40800000, 0x41100000, 0x41800000 -> grants 0,1,2,3 on consecutive edges; responses 0x3F800000, 0x40000000, 0x40400000, 0x40800000 in the same order, one per cycle; inflight peaks at 4.
- Fairness: req0 and req2 held valid continuously with rsp_ready=1 -> grants alternate 0,2,0,2; neither waits more than one grant.
- Hold response: rsp_ready[1]=0 for 10 cycles after rsp_valid[1] -> rsp_data[1] stable, req_ready[1] stays 0 while req_valid[1]=1, other requesters still served.
- Reset mid-flight: grant req3, assert rst one cycle later -> all outputs zero immediately, no rsp_valid appears after release, next grant starts from ptr=0.
- Re-issue gap: req1 with rsp_ready=1 and req_valid held -> next grant occurs exactly one cycle after the response handshake edge, never on the same edge.
